// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared definitions for the system-ID check controller:
//   - state_t     : controller state encoding
//   - ADDR_ID/TS  : slave word addresses (0 = ID word, 1 = build timestamp)
//   - word_match  : full-width equality helper used for the ID/TS compare
// -----------------------------------------------------------------------------
package sysid_check_pkg;

    typedef enum logic [3:0] {
        START   = 4'd0,
        ID_CMD  = 4'd1,
        ID_WAIT = 4'd2,
        TS_CMD  = 4'd3,
        TS_WAIT = 4'd4,
        CHECK   = 4'd5,
        DONE    = 4'd6,
        H_CMD   = 4'd7,
        H_WAIT  = 4'd8
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Full 32-bit equality between a read word and its expected value.
    function automatic logic word_match(input logic [31:0] actual,
                                        input logic [31:0] expected);
        return (actual == expected);
    endfunction

endpackage

// File: rtl/sysid_rd_timer.sv
// -----------------------------------------------------------------------------
// sysid_rd_timer
// Read-response watchdog. An 8-bit counter is cleared when a read command is
// accepted and counts every cycle spent waiting for m_readdatavalid.
// expire is raised during the wait cycle in which the wait length reaches
// LIMIT, so the FSM leaves the WAIT state on exactly LIMIT cycles after the
// accepting edge.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   clear  in  command accepted this cycle (restart the count)
//   enable in  FSM is in a WAIT state
//   expire out wait budget used up (combinational, qualified by enable)
// -----------------------------------------------------------------------------
module sysid_rd_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count_r;

    // Wait-cycle counter: cleared on acceptance, saturating increment in WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // count_r holds the number of completed wait cycles; the current cycle
    // is wait number count_r+1, hence the compare against LIMIT-1.
    assign expire = enable && !clear && (count_r >= 8'(LIMIT - 1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Avalon-MM master for the system-ID slave. After reset (and on each recheck
// pulse while idle) it reads word 0 (ID) and word 1 (build timestamp),
// compares both with the expected values and retries up to MAX_ATTEMPTS full
// passes. A read that gets no m_readdatavalid within TIMEOUT_CYCLES ends the
// check as failed with no retry. While idle in DONE it forwards single-word
// host reads to the same slave, so the slave only ever sees this master.
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   recheck               one-cycle pulse, honoured only in DONE
//   m_*                   Avalon-MM read master (registered m_read/m_address)
//   h_req/h_addr          host read request, held until h_ack
//   h_ack/h_rdata/h_err   one-cycle host response (h_err = timeout, data 0)
//   check_done/pass/fail  check status flags
//   id_value/ts_value     last words read during checking
//   attempts              passes used by the current/last check
// -----------------------------------------------------------------------------
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1461568625,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        recheck,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        h_req,
    input  logic        h_addr,
    output logic        h_ack,
    output logic [31:0] h_rdata,
    output logic        h_err,
    output logic        check_done,
    output logic        check_pass,
    output logic        check_fail,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  attempts
);

    state_t      state_r,      state_s;
    logic        m_read_r,     m_read_s;
    logic        m_address_r,  m_address_s;
    logic        h_addr_r,     h_addr_s;
    logic        h_ack_r,      h_ack_s;
    logic [31:0] h_rdata_r,    h_rdata_s;
    logic        h_err_r,      h_err_s;
    logic        done_r,       done_s;
    logic        pass_r,       pass_s;
    logic        fail_r,       fail_s;
    logic [31:0] id_r,         id_s;
    logic [31:0] ts_r,         ts_s;
    logic [3:0]  attempts_r,   attempts_s;

    logic        accepted_s;
    logic        waiting_s;
    logic        expire_s;

    // Command handshake completes when our registered read meets no stall.
    assign accepted_s = m_read_r && !m_waitrequest;
    assign waiting_s  = (state_r == ID_WAIT) || (state_r == TS_WAIT) ||
                        (state_r == H_WAIT);

    sysid_rd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (accepted_s),
        .enable (waiting_s),
        .expire (expire_s)
    );

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_s     = state_r;
        m_read_s    = 1'b0;
        m_address_s = m_address_r;
        h_addr_s    = h_addr_r;
        h_ack_s     = 1'b0;
        h_rdata_s   = 32'd0;
        h_err_s     = 1'b0;
        done_s      = done_r;
        pass_s      = pass_r;
        fail_s      = fail_r;
        id_s        = id_r;
        ts_s        = ts_r;
        attempts_s  = attempts_r;

        case (state_r)
            START: begin
                // Bounded by MAX_ATTEMPTS via CHECK; the guard only keeps
                // the counter from wrapping.
                if (attempts_r != 4'hF) begin
                    attempts_s = attempts_r + 4'd1;
                end else begin
                    attempts_s = attempts_r;
                end
                state_s = ID_CMD;
            end

            ID_CMD: begin
                if (accepted_s) begin
                    state_s = ID_WAIT;
                end else begin
                    m_read_s    = 1'b1;
                    m_address_s = ADDR_ID;
                end
            end

            ID_WAIT: begin
                if (m_readdatavalid) begin
                    id_s    = m_readdata;
                    state_s = TS_CMD;
                end else if (expire_s) begin
                    fail_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = ID_WAIT;
                end
            end

            TS_CMD: begin
                if (accepted_s) begin
                    state_s = TS_WAIT;
                end else begin
                    m_read_s    = 1'b1;
                    m_address_s = ADDR_TS;
                end
            end

            TS_WAIT: begin
                if (m_readdatavalid) begin
                    ts_s    = m_readdata;
                    state_s = CHECK;
                end else if (expire_s) begin
                    fail_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = TS_WAIT;
                end
            end

            CHECK: begin
                if (word_match(id_r, EXPECTED_ID) && word_match(ts_r, EXPECTED_TS)) begin
                    pass_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = DONE;
                end else if (attempts_r < 4'(MAX_ATTEMPTS)) begin
                    state_s = START;
                end else begin
                    fail_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = DONE;
                end
            end

            DONE: begin
                // recheck wins over a simultaneous host request; the host
                // request stays pending and is served after the new check.
                if (recheck) begin
                    done_s     = 1'b0;
                    pass_s     = 1'b0;
                    fail_s     = 1'b0;
                    attempts_s = 4'd0;
                    state_s    = START;
                end else if (h_req) begin
                    h_addr_s = h_addr;
                    state_s  = H_CMD;
                end else begin
                    state_s = DONE;
                end
            end

            H_CMD: begin
                if (accepted_s) begin
                    state_s = H_WAIT;
                end else begin
                    m_read_s    = 1'b1;
                    m_address_s = h_addr_r;
                end
            end

            H_WAIT: begin
                if (m_readdatavalid) begin
                    h_ack_s   = 1'b1;
                    h_rdata_s = m_readdata;
                    state_s   = DONE;
                end else if (expire_s) begin
                    h_ack_s   = 1'b1;
                    h_err_s   = 1'b1;
                    h_rdata_s = 32'd0;
                    state_s   = DONE;
                end else begin
                    state_s = H_WAIT;
                end
            end

            default: begin
                state_s = START;
            end
        endcase
    end

    // Controller state and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= START;
            m_read_r    <= 1'b0;
            m_address_r <= 1'b0;
            h_addr_r    <= 1'b0;
            h_ack_r     <= 1'b0;
            h_rdata_r   <= 32'd0;
            h_err_r     <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            id_r        <= 32'd0;
            ts_r        <= 32'd0;
            attempts_r  <= 4'd0;
        end else begin
            state_r     <= state_s;
            m_read_r    <= m_read_s;
            m_address_r <= m_address_s;
            h_addr_r    <= h_addr_s;
            h_ack_r     <= h_ack_s;
            h_rdata_r   <= h_rdata_s;
            h_err_r     <= h_err_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            fail_r      <= fail_s;
            id_r        <= id_s;
            ts_r        <= ts_s;
            attempts_r  <= attempts_s;
        end
    end

    assign m_read     = m_read_r;
    assign m_address  = m_address_r;
    assign h_ack      = h_ack_r;
    assign h_rdata    = h_rdata_r;
    assign h_err      = h_err_r;
    assign check_done = done_r;
    assign check_pass = pass_r;
    assign check_fail = fail_r;
    assign id_value   = id_r;
    assign ts_value   = ts_r;
    assign attempts   = attempts_r;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_ctrl
// Self-checking bench for sysid_check_ctrl (MAX_ATTEMPTS=3, TIMEOUT_CYCLES=10).
// A behavioural system-ID slave (configurable stall, bad TS words, silence)
// answers one cycle after acceptance. A table of check scenarios is applied
// in a loop, followed by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1461568625;

    logic        clock = 1'b0;
    logic        reset;
    logic        recheck;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        h_req;
    logic        h_addr;
    logic        h_ack;
    logic [31:0] h_rdata;
    logic        h_err;
    logic        check_done;
    logic        check_pass;
    logic        check_fail;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [3:0]  attempts;

    int checks = 0;
    int errors = 0;

    // slave configuration (written by the stimulus process only)
    logic [31:0] cfg_id_word    = 32'd0;
    logic [31:0] cfg_ts_bad_val = 32'd0;
    int          cfg_ts_bad_cnt = 0;
    int          cfg_ws         = 0;
    bit          cfg_silent     = 1'b0;
    bit          sl_clear       = 1'b1;

    // slave state (written by the slave process only)
    bit          acc_pend  = 1'b0;
    logic [31:0] acc_data  = 32'd0;
    int          acc_count = 0;
    int          id_acc    = 0;
    int          ts_seen   = 0;
    int          wait_left = 0;

    sysid_check_ctrl #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .MAX_ATTEMPTS   (3),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .recheck         (recheck),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .h_req           (h_req),
        .h_addr          (h_addr),
        .h_ack           (h_ack),
        .h_rdata         (h_rdata),
        .h_err           (h_err),
        .check_done      (check_done),
        .check_pass      (check_pass),
        .check_fail      (check_fail),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .attempts        (attempts)
    );

    always #5 clock = ~clock;

    // Slave model: decides stall/response for the coming posedge on each negedge.
    always @(negedge clock) begin
        if (acc_pend && !cfg_silent) begin
            m_readdatavalid = 1'b1;
            m_readdata      = acc_data;
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata      = 32'd0;
        end
        if (sl_clear) begin
            acc_count = 0;
            id_acc    = 0;
            ts_seen   = 0;
            wait_left = cfg_ws;
        end
        if (m_read === 1'b1 && wait_left > 0) begin
            m_waitrequest = 1'b1;
            wait_left     = wait_left - 1;
        end else begin
            m_waitrequest = 1'b0;
        end
        acc_pend = (m_read === 1'b1) && !m_waitrequest;
        if (acc_pend) begin
            acc_count = acc_count + 1;
            if (m_address === 1'b1) begin
                acc_data = (ts_seen < cfg_ts_bad_cnt) ? cfg_ts_bad_val : EXP_TS;
                ts_seen  = ts_seen + 1;
            end else begin
                acc_data = cfg_id_word;
                id_acc   = id_acc + 1;
            end
        end
    end

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: actual=%0d (0x%08h) required=%0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        sl_clear = 1'b1;
        repeat (3) tick;
        reset    = 1'b0;
        sl_clear = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (check_done !== 1'b1 && n < budget) begin
            tick;
            n = n + 1;
        end
        checks = checks + 1;
        if (check_done !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL wait_done: check_done=%b after %0d cycles, required 1", check_done, budget);
        end
    endtask

    typedef struct {
        logic [31:0] id_word;
        int          ts_bad_cnt;
        logic [31:0] ts_bad_val;
        int          ws;
        logic        exp_pass;
        logic        exp_fail;
        logic [3:0]  exp_att;
        int          exp_reads;
        logic [31:0] exp_id;
        logic [31:0] exp_ts;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int stalls;

        //           id      badcnt badval  ws pass fail att reads id      ts
        vecs[0] = '{32'd0,   0,     32'd0,  0, 1'b1, 1'b0, 4'd1, 2, 32'd0, EXP_TS};
        vecs[1] = '{32'd0,   100,   32'd0,  0, 1'b0, 1'b1, 4'd3, 6, 32'd0, 32'd0};
        vecs[2] = '{32'd0,   1,     32'd5,  0, 1'b1, 1'b0, 4'd2, 4, 32'd0, EXP_TS};
        vecs[3] = '{32'd0,   2,     32'd7,  0, 1'b1, 1'b0, 4'd3, 6, 32'd0, EXP_TS};
        vecs[4] = '{32'd1,   0,     32'd0,  0, 1'b0, 1'b1, 4'd3, 6, 32'd1, EXP_TS};
        vecs[5] = '{32'd0,   0,     32'd0,  4, 1'b1, 1'b0, 4'd1, 2, 32'd0, EXP_TS};

        reset   = 1'b1;
        recheck = 1'b0;
        h_req   = 1'b0;
        h_addr  = 1'b0;

        // ---- reset state and single-pass latency ----
        sl_clear = 1'b1;
        repeat (3) tick;
        chk("rst_check_done", 32'(check_done), 32'd0);
        chk("rst_check_pass", 32'(check_pass), 32'd0);
        chk("rst_check_fail", 32'(check_fail), 32'd0);
        chk("rst_attempts",   32'(attempts),   32'd0);
        chk("rst_m_read",     32'(m_read),     32'd0);
        chk("rst_h_ack",      32'(h_ack),      32'd0);
        reset    = 1'b0;
        sl_clear = 1'b0;
        repeat (7) tick;
        chk("lat_done_at_7", 32'(check_done), 32'd0);
        tick;
        chk("lat_done_at_8", 32'(check_done), 32'd1);
        chk("lat_pass_at_8", 32'(check_pass), 32'd1);
        chk("lat_att_at_8",  32'(attempts),   32'd1);

        // ---- table-driven check scenarios ----
        for (int i = 0; i < 6; i++) begin
            cfg_id_word    = vecs[i].id_word;
            cfg_ts_bad_cnt = vecs[i].ts_bad_cnt;
            cfg_ts_bad_val = vecs[i].ts_bad_val;
            cfg_ws         = vecs[i].ws;
            cfg_silent     = 1'b0;
            do_reset;
            wait_done(200);
            tick;
            chk($sformatf("vec%0d_pass", i),     32'(check_pass), 32'(vecs[i].exp_pass));
            chk($sformatf("vec%0d_fail", i),     32'(check_fail), 32'(vecs[i].exp_fail));
            chk($sformatf("vec%0d_attempts", i), 32'(attempts),   32'(vecs[i].exp_att));
            chk($sformatf("vec%0d_reads", i),    32'(acc_count),  32'(vecs[i].exp_reads));
            chk($sformatf("vec%0d_id", i),       id_value,        vecs[i].exp_id);
            chk($sformatf("vec%0d_ts", i),       ts_value,        vecs[i].exp_ts);
        end

        // ---- stalled ID command: m_read/m_address held stable ----
        cfg_id_word    = 32'd0;
        cfg_ts_bad_cnt = 0;
        cfg_ws         = 4;
        do_reset;
        stalls = 0;
        n = 0;
        while (check_done !== 1'b1 && n < 60) begin
            tick;
            n = n + 1;
            if (m_waitrequest === 1'b1) begin
                stalls = stalls + 1;
                chk("stall_m_read", 32'(m_read),    32'd1);
                chk("stall_m_addr", 32'(m_address), 32'd0);
            end
        end
        chk("stall_done",     32'(check_done), 32'd1);
        chk("stall_cycles",   32'(stalls),     32'd4);
        chk("stall_id_reads", 32'(id_acc),     32'd1);
        cfg_ws = 0;

        // ---- silent slave: check timeout then host timeout ----
        cfg_silent = 1'b1;
        do_reset;
        n = 0;
        while (acc_count != 1 && n < 20) begin
            tick;
            n = n + 1;
        end
        chk("to_cmd_accepted", 32'(acc_count), 32'd1);
        repeat (10) tick;
        chk("to_fail_early", 32'(check_fail), 32'd0);
        tick;
        chk("to_fail",     32'(check_fail), 32'd1);
        chk("to_done",     32'(check_done), 32'd1);
        chk("to_pass",     32'(check_pass), 32'd0);
        chk("to_attempts", 32'(attempts),   32'd1);
        chk("to_reads",    32'(acc_count),  32'd1);
        h_req  = 1'b1;
        h_addr = 1'b1;
        n = 0;
        while (h_ack !== 1'b1 && n < 40) begin
            tick;
            n = n + 1;
        end
        h_req = 1'b0;
        chk("hto_ack",   32'(h_ack),      32'd1);
        chk("hto_err",   32'(h_err),      32'd1);
        chk("hto_rdata", h_rdata,         32'd0);
        chk("hto_fail",  32'(check_fail), 32'd1);
        chk("hto_pass",  32'(check_pass), 32'd0);
        cfg_silent = 1'b0;

        // ---- recheck and h_req together in DONE: recheck first ----
        do_reset;
        wait_done(100);
        tick;
        recheck = 1'b1;
        h_req   = 1'b1;
        h_addr  = 1'b1;
        tick;
        recheck = 1'b0;
        chk("pri_done_cleared", 32'(check_done), 32'd0);
        chk("pri_att_cleared",  32'(attempts),   32'd0);
        n = 0;
        while (h_ack !== 1'b1 && n < 60) begin
            tick;
            n = n + 1;
        end
        h_req = 1'b0;
        chk("pri_ack",   32'(h_ack),      32'd1);
        chk("pri_err",   32'(h_err),      32'd0);
        chk("pri_rdata", h_rdata,         EXP_TS);
        chk("pri_pass",  32'(check_pass), 32'd1);
        chk("pri_att",   32'(attempts),   32'd1);
        chk("pri_reads", 32'(acc_count),  32'd5);
        tick;
        chk("pri_ack_pulse", 32'(h_ack), 32'd0);

        // ---- reset asserted during ID_WAIT ----
        do_reset;
        n = 0;
        while (acc_count != 1 && n < 20) begin
            tick;
            n = n + 1;
        end
        tick;
        reset = 1'b1;
        tick;
        chk("midrst_m_read",   32'(m_read),     32'd0);
        chk("midrst_attempts", 32'(attempts),   32'd0);
        chk("midrst_done",     32'(check_done), 32'd0);
        chk("midrst_h_ack",    32'(h_ack),      32'd0);
        tick;
        reset = 1'b0;
        wait_done(100);
        tick;
        chk("midrst_pass",     32'(check_pass), 32'd1);
        chk("midrst_att",      32'(attempts),   32'd1);
        chk("midrst_ts",       ts_value,        EXP_TS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Avalon-MM master that sequences reads of the system-ID slave: word 0 is the ID, word 1 is the build timestamp.
- After reset, and on each recheck request, it reads both words and compares them against expected values, retrying on mismatch.
- It then reports pass/fail to the boot/status logic.
- Once checking is idle, it also services single-word host reads of the same slave, so the slave has exactly one master.

Parameters:
- EXPECTED_ID, 32'd0, required value at slave word 0.
- EXPECTED_TS, 32'd1461568625, required value at slave word 1.
- MAX_ATTEMPTS, 3, full ID+TS read passes before declaring fail (1..15).
- TIMEOUT_CYCLES, 255, cycles allowed from command acceptance to m_readdatavalid (1..255).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- recheck  in  1  one-cycle pulse; restarts the check sequence.
- m_address  out  1  slave word select (0=ID, 1=TS).
- m_read  out  1  read command.
- m_waitrequest  in  1  slave stall; command is accepted when m_read=1 and m_waitrequest=0.
- m_readdata  in  32  read data.
- m_readdatavalid  in  1  m_readdata valid this cycle.
- h_req  in  1  host read request; held until h_ack.
- h_addr  in  1  host word select.
- h_ack  out  1  one-cycle pulse with h_rdata valid.
- h_rdata  out  32  host read data.
- h_err  out  1  valid with h_ack; 1 = timeout, h_rdata=0.
- check_done  out  1  check finished (pass or fail).
- check_pass  out  1  ID and TS matched.
- check_fail  out  1  attempts exhausted or timeout.
- id_value  out  32  last ID read.
- ts_value  out  32  last TS read.
- attempts  out  4  passes used in the current/last check.

Behaviour:
- Reset: all outputs 0; state=START; attempts=0. Reset mid-transaction abandons it; a late m_readdatavalid after reset is ignored (only sampled in *_WAIT states).
- State flow:
  - START -> ID_CMD, incrementing attempts.
  - ID_CMD: m_read=1, m_address=0; hold until accepted -> ID_WAIT.
  - ID_WAIT: on m_readdatavalid, latch id_value -> TS_CMD.
  - TS_CMD / TS_WAIT: same as ID, with m_address=1 and latch into ts_value -> CHECK.
  - CHECK (one cycle):
    - both equal expected -> DONE; check_pass=1, check_done=1.
    - else if attempts<MAX_ATTEMPTS -> START.
    - else -> DONE; check_fail=1, check_done=1.
- Timeout: a 8-bit counter clears on command acceptance and increments each WAIT cycle. Reaching TIMEOUT_CYCLES in ID_WAIT or TS_WAIT -> DONE with check_fail=1 immediately; no retry.
- m_read and m_address are registered.
  - m_read rises the cycle after entering a CMD state.
  - m_read drops the cycle after acceptance.
  - Never more than one outstanding read.
- DONE is idle:
  - recheck=1 -> START; clears check_done, check_pass, check_fail and attempts the same cycle. recheck has priority over h_req when both are asserted.
  - else h_req=1 -> H_CMD with h_addr captured.
- H_CMD / H_WAIT: same handshake as the check states.
  - On m_readdatavalid: h_ack=1 and h_rdata=m_readdata for one cycle, h_err=0 -> DONE.
  - On timeout: h_ack=1, h_err=1, h_rdata=0 -> DONE. Check flags are not altered.
- recheck outside DONE: ignored, no queuing.
- h_req outside DONE: stalls with no h_ack until DONE is reached.
- Latency, zero-wait slave with readdatavalid one cycle after acceptance: reset deassert to check_done = 8 cycles for a single passing attempt. Host read in DONE to h_ack = 4 cycles.
- Comparisons are full 32-bit equality.
- attempts saturates by construction (≤MAX_ATTEMPTS).

Decomposition:
- Package sysid_check_pkg:
  - state enum (START, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, CHECK, DONE, H_CMD, H_WAIT);
  - word-address constants ADDR_ID=0, ADDR_TS=1.
- One sub-module, sysid_rd_timer: the timeout counter with clear, enable and expire outputs.
- All else lives in a single FSM module.

Test Plan:
- Zero-wait slave returns 0 / 1461568625 -> check_pass=1, check_done=1, attempts=1 exactly 8 cycles after reset deasserts.
- Slave returns TS=0 on every read, MAX_ATTEMPTS=3 -> 6 reads issued, then check_fail=1, attempts=3, ts_value=0.
- First pass returns TS=5, second pass correct -> check_pass=1, attempts=2.
- m_waitrequest held 4 cycles on the ID read -> m_read held stable with m_address=0 throughout; exactly one read accepted.
- m_readdatavalid never asserted, TIMEOUT_CYCLES=10 -> check_fail=1 10 cycles after acceptance. Subsequent h_req for addr 1 with the slave still silent -> h_ack with h_err=1, h_rdata=0.
- In DONE, recheck and h_req asserted the same cycle -> re-check runs first. Host then gets h_ack with h_rdata=1461568625 for h_addr=1. reset asserted during ID_WAIT -> all outputs 0 next cycle, and the sequence restarts.
